pcm_i2s_rx: RTL and testbench

PCM_I2S_RX -- requirements
Module: pcm_i2s_rx

---
 rtl/pcm_pkg.sv | 32 +++
 rtl/pcm_rate_detect.sv | 130 +++++++++++++
 rtl/pcm_i2s_rx.sv | 130 +++++++++++++
 tb/tb_pcm_i2s_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared constants for the PCM I2S receiver: rate codes, nominal LRCK periods and widths.
package pcm_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PER_W   = 11;
    localparam int unsigned BCNT_W  = 6;

    localparam logic [PER_W-1:0] PER_MAX = '1;

    typedef enum logic [1:0] {
        RATE_44K1  = 2'b00,
        RATE_88K2  = 2'b01,
        RATE_176K4 = 2'b10,
        RATE_352K8 = 2'b11
    } rate_e;

    localparam logic [PER_W-1:0] NOM_44K1  = PER_W'(1024);
    localparam logic [PER_W-1:0] NOM_88K2  = PER_W'(512);
    localparam logic [PER_W-1:0] NOM_176K4 = PER_W'(256);
    localparam logic [PER_W-1:0] NOM_352K8 = PER_W'(128);

    // Nominal LRCK period in mclk cycles for a rate code.
    function automatic logic [PER_W-1:0] nominal_period(input logic [1:0] code);
        case (code)
            2'b00:   nominal_period = NOM_44K1;
            2'b01:   nominal_period = NOM_88K2;
            2'b10:   nominal_period = NOM_176K4;
            default: nominal_period = NOM_352K8;
        endcase
    endfunction

endpackage

// File: rtl/pcm_rate_detect.sv
// Measures the synchronized LRCK period, classifies it into a rate code and
// runs the lock FSM that qualifies ctrl/locked.
module pcm_rate_detect
    import pcm_pkg::*;
#(
    parameter int unsigned TOL      = 8,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic       i_mclk,
    input  logic       i_reset,
    input  logic       i_lrck_sync,
    output logic [1:0] o_ctrl,
    output logic       o_locked
);

    localparam int unsigned EXT_W   = PER_W + 1;
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

    typedef enum logic {
        ST_UNLOCK = 1'b0,
        ST_LOCK   = 1'b1
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [MATCH_W-1:0]   r_match, w_match_nxt;
    rate_e                r_cls, w_cls_nxt;
    rate_e                r_ctrl, w_ctrl_nxt;
    logic [PER_W-1:0]     r_cnt;
    logic                 r_lrck_d;
    logic                 r_run;

    logic                 w_lr_rise;
    logic                 w_sat;
    logic                 w_meas;
    logic                 w_valid;
    rate_e                w_cls;

    function automatic logic in_window(input logic [PER_W-1:0] p, input logic [PER_W-1:0] nom);
        return ((EXT_W'(p) + EXT_W'(TOL)) >= EXT_W'(nom)) &&
               (EXT_W'(p) <= (EXT_W'(nom) + EXT_W'(TOL)));
    endfunction

    assign w_lr_rise = i_lrck_sync & ~r_lrck_d;
    assign w_sat     = (r_cnt == PER_MAX);
    // The first rise after reset only starts the measurement.
    assign w_meas    = w_lr_rise & r_run;

    always_comb begin
        w_valid = 1'b0;
        w_cls   = RATE_44K1;
        for (int i = 0; i < 4; i++) begin
            if (!w_valid && in_window(r_cnt, nominal_period(2'(i)))) begin
                w_valid = 1'b1;
                w_cls   = rate_e'(2'(i));
            end
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_lrck_d <= 1'b0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else begin
            r_lrck_d <= i_lrck_sync;
            if (w_lr_rise) begin
                r_cnt <= PER_W'(1);
                r_run <= 1'b1;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + PER_W'(1);
            end
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_state <= ST_UNLOCK;
            r_match <= '0;
            r_cls   <= RATE_44K1;
            r_ctrl  <= RATE_44K1;
        end else begin
            r_state <= w_state_nxt;
            r_match <= w_match_nxt;
            r_cls   <= w_cls_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_cls_nxt   = r_cls;
        w_ctrl_nxt  = r_ctrl;
        case (r_state)
            ST_UNLOCK: begin
                if (w_meas) begin
                    if (!w_valid) begin
                        w_match_nxt = '0;
                    end else if ((r_match != '0) && (w_cls == r_cls)) begin
                        w_match_nxt = r_match + MATCH_W'(1);
                    end else begin
                        w_match_nxt = MATCH_W'(1);
                        w_cls_nxt   = w_cls;
                    end
                    if (w_valid && (w_match_nxt >= MATCH_W'(LOCK_CNT))) begin
                        w_state_nxt = ST_LOCK;
                        w_ctrl_nxt  = w_cls;
                    end
                end else if (w_sat) begin
                    w_match_nxt = '0;
                end
            end
            ST_LOCK: begin
                // ctrl is held on unlock; only the match count restarts.
                if (w_sat || (w_meas && (!w_valid || (w_cls != r_ctrl)))) begin
                    w_state_nxt = ST_UNLOCK;
                    w_match_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCK;
                w_match_nxt = '0;
            end
        endcase
    end

    assign o_ctrl   = r_ctrl;
    assign o_locked = (r_state == ST_LOCK);

endmodule

// File: rtl/pcm_i2s_rx.sv
// I2S receiver: synchronizes the serial pins into mclk, deserializes 32-bit
// left/right words and publishes stereo pairs once the rate detector is locked.
module pcm_i2s_rx
    import pcm_pkg::*;
#(
    parameter int unsigned TOL      = 8,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              sdata,
    output logic [WORD_W-1:0] xl,
    output logic [WORD_W-1:0] xr,
    output logic              start,
    output logic [1:0]        ctrl,
    output logic              locked,
    output logic              frame_err
);

    logic [1:0]        r_bclk_s, r_lrck_s, r_sdata_s;
    logic              r_bclk_d;
    logic              r_lr_prev;
    logic              r_have_lr;
    logic              r_framed;
    logic [BCNT_W-1:0] r_bcnt;
    logic [WORD_W-2:0] r_shift;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_v;
    logic [WORD_W-1:0] r_xl, r_xr;
    logic              r_start, r_frame_err;

    logic              w_bclk, w_lr, w_sd;
    logic              w_rise, w_edge, w_done, w_len_ok;
    logic              w_bad, w_left_done, w_right_done;
    logic [WORD_W-1:0] w_word;
    logic              w_locked;

    pcm_rate_detect #(
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_rate (
        .i_mclk      (mclk),
        .i_reset     (reset),
        .i_lrck_sync (w_lr),
        .o_ctrl      (ctrl),
        .o_locked    (w_locked)
    );

    assign w_bclk = r_bclk_s[1];
    assign w_lr   = r_lrck_s[1];
    assign w_sd   = r_sdata_s[1];
    assign w_rise = w_bclk & ~r_bclk_d;

    // An lrck change seen on a bclk rise closes the old channel with this bit as LSB.
    assign w_edge       = w_rise & r_have_lr & (w_lr != r_lr_prev);
    assign w_word       = {r_shift, w_sd};
    assign w_len_ok     = (r_bcnt == BCNT_W'(WORD_W - 1));
    assign w_done       = w_edge & r_framed;
    assign w_bad        = w_done & ~w_len_ok;
    assign w_left_done  = w_done & w_len_ok & ~r_lr_prev;
    assign w_right_done = w_done & w_len_ok & r_lr_prev;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_bclk_s    <= '0;
            r_lrck_s    <= '0;
            r_sdata_s   <= '0;
            r_bclk_d    <= 1'b0;
            r_lr_prev   <= 1'b0;
            r_have_lr   <= 1'b0;
            r_framed    <= 1'b0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_v    <= 1'b0;
            r_xl        <= '0;
            r_xr        <= '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_bclk_s    <= {r_bclk_s[0], bclk};
            r_lrck_s    <= {r_lrck_s[0], lrck};
            r_sdata_s   <= {r_sdata_s[0], sdata};
            r_bclk_d    <= w_bclk;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_rise) begin
                r_shift   <= w_word[WORD_W-2:0];
                r_lr_prev <= w_lr;
                r_have_lr <= 1'b1;
                if (w_edge) begin
                    r_bcnt   <= '0;
                    r_framed <= 1'b1;
                end else if (r_bcnt != '1) begin
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end

            if (w_bad) begin
                r_frame_err <= 1'b1;
                r_hold_v    <= 1'b0;
            end

            if (w_left_done) begin
                r_hold   <= w_word;
                r_hold_v <= 1'b1;
            end

            // A pair is published only with a held left and an active lock.
            if (w_right_done) begin
                r_hold_v <= 1'b0;
                if (r_hold_v && w_locked) begin
                    r_xl    <= r_hold;
                    r_xr    <= w_word;
                    r_start <= 1'b1;
                end
            end
        end
    end

    assign xl        = r_xl;
    assign xr        = r_xr;
    assign start     = r_start;
    assign locked    = w_locked;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_pcm_i2s_rx.sv
// Scoreboard bench for pcm_i2s_rx: an I2S frame driver feeds a rate/lock model
// that predicts each published stereo pair and its arrival cycle.
`timescale 1ns/1ps
module tb_pcm_i2s_rx;

    localparam int TOL      = 8;
    localparam int LOCK_CNT = 2;

    logic        mclk = 1'b0;
    logic        reset, bclk, lrck, sdata;
    logic [31:0] xl, xr;
    logic        start, locked, frame_err;
    logic [1:0]  ctrl;

    pcm_i2s_rx #(.TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdata     (sdata),
        .xl        (xl),
        .xr        (xr),
        .start     (start),
        .ctrl      (ctrl),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #11 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          t;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_ferr = 0;
    int          exp_ferr = 0;

    // reference model state
    int          m_run = 0;
    int          m_cls = -1;
    int          last_rise = -1;
    bit          after_reset = 1'b1;
    bit          pend_v = 1'b0;
    bit          pend_bad = 1'b0;
    bit          pend_lsb = 1'b0;
    logic [31:0] pend_l = '0, pend_r = '0;
    logic [31:0] last_l = '0, last_r = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge mclk) begin
        if (!reset && start) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_start: xl=%h xr=%h at cycle %0d", xl, xr, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("xl", xl, mon_e.l);
                chk("xr", xr, mon_e.r);
                chk("start_cycle", 32'(cyc), 32'(mon_e.t));
            end
        end
        if (!reset && frame_err) n_ferr++;
    end

    // Rate/lock model: classify the period between lrck rises at pin level.
    task automatic model_rise(input int c);
        int p;
        int cls;
        if (last_rise >= 0) begin
            p   = c - last_rise;
            if (p > 2047) p = 2047;
            cls = -1;
            for (int k = 0; k < 4; k++) begin
                if (p >= (1024 >> k) - TOL && p <= (1024 >> k) + TOL) cls = k;
            end
            if (cls < 0) m_run = 0;
            else if (m_run >= LOCK_CNT && cls != m_cls) m_run = 0;
            else if (m_run > 0 && cls == m_cls) m_run++;
            else begin
                m_run = 1;
                m_cls = cls;
            end
        end
        last_rise = c;
    endtask

    task automatic bclk_cyc(input bit lr, input bit sd, input int h, input bit lr_rise, input bit push);
        exp_t e;
        bclk  = 1'b0;
        lrck  = lr;
        sdata = sd;
        if (lr_rise) model_rise(cyc);
        repeat (h) @(negedge mclk);
        bclk = 1'b1;
        if (push) begin
            e.l = pend_l;
            e.r = pend_r;
            e.t = cyc + 3;
            sb_q.push_back(e);
            last_l = pend_l;
            last_r = pend_r;
        end
        repeat (h) @(negedge mclk);
    endtask

    // One stereo frame; rcyc<32 truncates the right word, lcyc<32 aborts in the left word.
    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int h,
                              input int rcyc, input int gap, input int lcyc);
        bit push;
        push = pend_v && (m_run >= LOCK_CNT);
        if (pend_bad) exp_ferr++;
        pend_v   = 1'b0;
        pend_bad = 1'b0;
        bclk_cyc(1'b0, pend_lsb, h, 1'b0, push);
        for (int c = 1; c < 32; c++) begin
            if (c >= lcyc) return;
            bclk_cyc(1'b0, l[32-c], h, 1'b0, 1'b0);
        end
        bclk_cyc(1'b1, l[0], h, 1'b1, 1'b0);
        for (int c = 1; c < rcyc; c++) bclk_cyc(1'b1, r[32-c], h, 1'b0, 1'b0);
        pend_lsb = r[0];
        if (gap > 0) begin
            bclk = 1'b0;
            repeat (gap) @(negedge mclk);
        end
        pend_l      = l;
        pend_r      = r;
        pend_v      = (rcyc == 32) && !after_reset;
        pend_bad    = (rcyc != 32);
        after_reset = 1'b0;
    endtask

    task automatic rnd_frames(input int n, input int h);
        for (int i = 0; i < n; i++) send_frame($urandom, $urandom, h, 32, 0, 32);
    endtask

    task automatic stop_lrck(input int n);
        bclk = 1'b0;
        repeat (n) @(negedge mclk);
        m_run = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        @(negedge mclk);
        chk("rst_xl", xl, 32'h0);
        chk("rst_xr", xr, 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_ctrl", 32'(ctrl), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_pending_starts", 32'(sb_q.size()), 32'h0);
        repeat (n - 1) @(negedge mclk);
        reset       = 1'b0;
        m_run       = 0;
        last_rise   = -1;
        pend_v      = 1'b0;
        pend_bad    = 1'b0;
        after_reset = 1'b1;
    endtask

    initial begin
        bclk  = 1'b0;
        lrck  = 1'b0;
        sdata = 1'b0;
        reset = 1'b1;
        @(negedge mclk);
        do_reset(3);

        // 44.1k: lock, fixed pair in mid-stream
        rnd_frames(4, 8);
        send_frame(32'h12345678, 32'h9ABCDEF0, 8, 32, 0, 32);
        rnd_frames(2, 8);
        chk("ctrl_44k1", 32'(ctrl), 32'd0);
        chk("locked_44k1", 32'(locked), 32'd1);

        // 352.8k with bclk = mclk/2 and full-scale values
        rnd_frames(3, 1);
        send_frame(32'h80000000, 32'h7FFFFFFF, 1, 32, 0, 32);
        rnd_frames(1, 1);
        chk("xl_neg_full", xl, 32'h80000000);
        chk("xr_pos_full", xr, 32'h7FFFFFFF);
        rnd_frames(1, 1);
        chk("ctrl_352k8", 32'(ctrl), 32'd3);
        chk("locked_352k8", 32'(locked), 32'd1);

        // 44.1k with a 1030 period (kept) then a 1040 period (lost)
        rnd_frames(4, 8);
        send_frame($urandom, $urandom, 8, 32, 6, 32);
        rnd_frames(1, 8);
        chk("locked_1030", 32'(locked), 32'd1);
        chk("ctrl_1030", 32'(ctrl), 32'd0);
        send_frame($urandom, $urandom, 8, 32, 16, 32);
        rnd_frames(1, 8);
        chk("locked_1040", 32'(locked), 32'd0);
        chk("ctrl_1040_hold", 32'(ctrl), 32'd0);
        chk("xl_hold", xl, last_l);
        chk("xr_hold", xr, last_r);
        rnd_frames(1, 8);
        chk("xl_hold2", xl, last_l);
        chk("xr_hold2", xr, last_r);
        rnd_frames(1, 8);

        // truncated right word, padded so the lrck period stays nominal
        send_frame($urandom, $urandom, 8, 31, 16, 32);
        rnd_frames(2, 8);
        chk("frame_err_seen", 32'(n_ferr), 32'(exp_ferr));
        chk("locked_after_trunc", 32'(locked), 32'd1);

        // lrck stop then restart at 88.2k
        stop_lrck(2200);
        chk("locked_stop", 32'(locked), 32'd0);
        chk("ctrl_stop_hold", 32'(ctrl), 32'd0);
        rnd_frames(4, 4);
        chk("ctrl_88k2", 32'(ctrl), 32'd1);
        chk("locked_88k2", 32'(locked), 32'd1);

        // reset in the middle of a left word while locked, then relock
        send_frame($urandom, $urandom, 4, 32, 0, 10);
        do_reset(2);
        rnd_frames(4, 4);
        chk("relock_ctrl", 32'(ctrl), 32'd1);
        chk("relock_locked", 32'(locked), 32'd1);
        rnd_frames(1, 4);

        repeat (50) @(negedge mclk);
        chk("missing_starts", 32'(sb_q.size()), 32'd0);
        chk("frame_err_count", 32'(n_ferr), 32'(exp_ferr));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
